// File: rtl/sel_scan_sequencer.sv
// sel_scan_sequencer: steps a 3-bit decoder select through a programmable range with per-channel dwell.
module sel_scan_sequencer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               mode_single_i,
   input  logic               dir_down_i,
   input  logic [2:0]         first_sel_i,
   input  logic [2:0]         last_sel_i,
   input  logic [DWELL_W-1:0] dwell_i,
   output logic               s2_o,
   output logic               s1_o,
   output logic               s0_o,
   output logic               valid_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               wrap_o
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SCAN = 1'b1;
   logic [0:0]         state_q, state_d;
   logic [2:0]         idx_q, idx_d, first_q, first_d, last_q, last_d, step;
   logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
   logic               single_q, single_d, down_q, down_d, done_q, done_d, wrap_q, wrap_d;
   assign step = down_q ? idx_q - 3'd1 : idx_q + 3'd1;
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      first_d  = first_q;
      last_d   = last_q;
      dwell_d  = dwell_q;
      single_d = single_q;
      down_d   = down_q;
      done_d   = 1'b0;
      wrap_d   = 1'b0;
      if (state_q == IDLE) begin
         if (start_i && !stop_i) begin
            state_d  = SCAN;
            first_d  = first_sel_i;
            last_d   = last_sel_i;
            dwell_d  = dwell_i;
            single_d = mode_single_i;
            down_d   = dir_down_i;
            idx_d    = first_sel_i;
            cnt_d    = dwell_i;
         end
      end else if (stop_i) begin
         state_d = IDLE;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - DWELL_W'(1);
      end else if (idx_q != last_q) begin
         idx_d = step;
         cnt_d = dwell_q;
      end else if (single_q) begin
         state_d = IDLE;
         done_d  = 1'b1;
      end else begin
         idx_d  = first_q;
         cnt_d  = dwell_q;
         wrap_d = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         first_q  <= '0;
         last_q   <= '0;
         dwell_q  <= '0;
         single_q <= 1'b0;
         down_q   <= 1'b0;
         done_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         first_q  <= first_d;
         last_q   <= last_d;
         dwell_q  <= dwell_d;
         single_q <= single_d;
         down_q   <= down_d;
         done_q   <= done_d;
         wrap_q   <= wrap_d;
      end
   end
   assign {s2_o, s1_o, s0_o} = idx_q;
   assign valid_o = state_q == SCAN;
   assign busy_o  = state_q == SCAN;
   assign done_o  = done_q;
   assign wrap_o  = wrap_q;
endmodule
